pipelined_chunk_adder: RTL and testbench
========================================

# pipelined_chunk_adder

Parametrised pipelined adder that splits a WIDTH-bit addition into CHUNK-bit slices and adds one slice per pipeline stage, rippling the carry through registers. It is the next-generation pipelined adder in the arithmetic datapath: any operand width, any slice size, and a carry-in. It adds full valid/ready backpressure with bubble collapsing, so it can sit between streaming producers and consumers that stall.

## Interface
- WIDTH, 16, operand width in bits.
- CHUNK, 4, slice width added per stage.
- STAGES, WIDTH/CHUNK, derived pipeline depth; not overridable.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  block can accept operands this cycle.
- data_1  in  WIDTH  operand A.
- data_2  in  WIDTH  operand B.
- carry_i  in  1  carry into bit 0.
- sub_i  in  1  1 selects A−B; present only with PCA_SUB_EN.
- data_out  out  WIDTH+1  result; MSB is carry-out.
- valid_o  out  1  data_out valid.
- ready_i  in  1  downstream accepts data_out.

## Operation
- Elaboration error if WIDTH % CHUNK != 0, or if CHUNK < 1, or if WIDTH < CHUNK.
- Stage s (1..STAGES) holds the following:
  - a valid bit;
  - result bits [s·CHUNK−1:0];
  - a carry;
  - the unconsumed upper operand slices.
- Stage 1 loads slice 0 of the input operands, summed combinationally with carry_i. Stage s+1 adds slice s plus the stage-s carry.
- Result: data_out = {carry_out, (data_1 + data_2 + carry_i) mod 2^WIDTH}, exact to WIDTH+1 bits.
- Enables:
  - en_STAGES = !valid_o || ready_i.
  - en_s = !v_s || en_{s+1}.
  - ready_o = en_1.
- Stage s loads stage s−1 (or the inputs for s=1) when en_s. Its valid bit becomes upstream valid, or valid_i && ready_o for stage 1.
- Handshake: an input transfer occurs on an edge with valid_i && ready_o; an output transfer occurs on an edge with valid_o && ready_i.
- Bubbles collapse: an empty stage always accepts, even while the output is stalled.
- Data registers load only on enable, so their contents are held otherwise. data_out is stable while valid_o && !ready_i.
- Operands may change freely while ready_o=0. They are not sampled.

## Timing
- Reset (asynchronous, immediate): all valid bits 0, all data registers and data_out 0, valid_o 0.
- ready_o is 1 from reset release.
- Latency: a transfer on edge T into an empty pipe with ready_i=1 gives valid_o=1 after edge T+STAGES−1, i.e. STAGES cycles including the accepting edge.
- Throughput: one result per cycle when ready_i=1.
- ready_o is combinational from ready_i and the valid bits only, through STAGES levels. There is no combinational path from valid_i or the data inputs to ready_o.
- Full pipe with ready_i=0: ready_o=0 next to the same edge state. STAGES operands are held, and none are lost or duplicated.
- ready_i rises while the pipe is full: a new operand is accepted on the same edge the output transfers.
- Reset asserted mid-operation: all in-flight operands are discarded, valid_o drops asynchronously, and no partial results appear after release.
- Wrap-around: 2^WIDTH−1 + 1 gives the MSB set and the low bits 0.

## Configuration
- PCA_SUB_EN defined:
  - sub_i port exists and travels with each operand.
  - sub_i=1 computes data_1 + ~data_2 + 1, and carry_i is ignored.
  - MSB=1 means no borrow (data_1 ≥ data_2).
  - sub_i=0 is identical to the base add.
- PCA_SUB_EN undefined: the sub_i port is absent and the block is add-only. No sub-related flops are present.

## Structure
- Package pipelined_chunk_adder_pkg holds the following:
  - the stages_f(WIDTH,CHUNK) function;
  - a parameter-check macro/function;
  - a stage-payload struct generator typedef for default widths.
- One sub-module, pca_stage. It holds one stage's registers and its CHUNK-bit slice adder (carry in/out) and is instantiated STAGES times by generate.

## Test plan
- WIDTH=16, CHUNK=4: 0xFFFF + 0x0001, carry_i=0 → data_out=0x10000 with valid_o after 4 cycles. 0x1234+0x4321, carry_i=1 → 0x05556.
- Back-to-back: 0x0001+0x0001, 0x00FF+0x0001, 0x0FFF+0x0001, 0x7FFF+0x8000 on consecutive cycles, ready_i=1 → 0x00002, 0x00100, 0x01000, 0x0FFFF on consecutive cycles.
- Stall: fill with 4 operands, hold ready_i=0 for 5 cycles.
  - ready_o=0 after the pipe is full.
  - data_out is held.
  - After ready_i=1, all 4 results come out in order, with no drop or duplicate.
- Bubble collapse: ready_i=0, with valid_i pulsed every other cycle → 4 operands accepted before ready_o falls.
- Reset mid-stream: assert rst_n=0 with 3 operands in flight.
  - valid_o=0 and data_out=0 immediately.
  - After release, the first result is only the next accepted operand's.
- With PCA_SUB_EN: 0x0005 − 0x0007 → 0x0FFFE (MSB=0). 0x0007 − 0x0005 → 0x10002.

Source files
------------

// File: rtl/pipelined_chunk_adder_pkg.sv
// pipelined_chunk_adder_pkg: shared sizing helpers and types for the chunked
// pipelined adder (pipelined_chunk_adder, pca_stage, pipelined_chunk_adder_if).
package pipelined_chunk_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Pipeline depth: one stage per CHUNK-bit slice.
    function automatic int stages_f(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    // Legal geometry: positive slice, at least one slice, whole slices only.
    function automatic bit params_ok_f(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Payload width entering stage idx (0-based): both operands' remaining
    // slices plus the result bits already produced.
    function automatic int payload_w_f(input int width, input int chunk, input int idx);
        return 2 * width - idx * chunk;
    endfunction

    // Logical view of one stage's state at the default geometry.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] res;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
    } pca_payload_t;

endpackage

// File: rtl/pipelined_chunk_adder_if.sv
// pipelined_chunk_adder_if: operand/result stream with valid/ready on both
// sides. sub_i exists only when PCA_SUB_EN is defined.
interface pipelined_chunk_adder_if
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic             carry_i;
`ifdef PCA_SUB_EN
    logic             sub_i;
`endif
    logic [WIDTH:0]   data_out;
    logic             valid_o;
    logic             ready_i;

`ifdef PCA_SUB_EN
    modport master (output valid_i, data_1, data_2, carry_i, sub_i, ready_i,
                    input  ready_o, data_out, valid_o);
    modport slave  (input  valid_i, data_1, data_2, carry_i, sub_i, ready_i,
                    output ready_o, data_out, valid_o);
`else
    modport master (output valid_i, data_1, data_2, carry_i, ready_i,
                    input  ready_o, data_out, valid_o);
    modport slave  (input  valid_i, data_1, data_2, carry_i, ready_i,
                    output ready_o, data_out, valid_o);
`endif

endinterface

// File: rtl/pca_stage.sv
// pca_stage: one pipeline stage. Adds the lowest remaining operand slice plus
// the incoming carry and registers {a_hi, b_hi, result-so-far} with its carry.
// Payload layout, LSB first: result bits, then B's remaining slices, then A's.
module pca_stage
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int IDX   = 0,
    localparam int IN_W  = payload_w_f(WIDTH, CHUNK, IDX),
    localparam int OUT_W = payload_w_f(WIDTH, CHUNK, IDX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_down_i,
    input  logic             valid_up_i,
    input  logic             carry_up_i,
    input  logic [IN_W-1:0]  pl_up_i,
    output logic             en_o,
    output logic             valid_o,
    output logic             carry_o,
    output logic [OUT_W-1:0] pl_o
);
    localparam int RES_IN_W = IDX * CHUNK;            // result bits already formed
    localparam int REM_IN_W = WIDTH - IDX * CHUNK;    // slices left per operand, incl. this one
    localparam int HI_W     = REM_IN_W - CHUNK;       // slices left after this stage

    // Masks let the first stage (no result yet) and the last stage (no
    // operands left) share one expression without zero-width slices.
    localparam logic [IN_W-1:0] ONE       = IN_W'(1);
    localparam logic [IN_W-1:0] RES_MASK  = (ONE << RES_IN_W) - ONE;
    localparam logic [IN_W-1:0] HI_ONES   = (ONE << HI_W) - ONE;
    localparam logic [IN_W-1:0] B_HI_MASK = HI_ONES << (RES_IN_W + CHUNK);
    localparam logic [IN_W-1:0] A_HI_MASK = HI_ONES << (RES_IN_W + REM_IN_W);

    logic             valid_q;
    logic             carry_q;
    logic [OUT_W-1:0] pl_q;
    logic [OUT_W-1:0] pl_d;
    logic [CHUNK:0]   sum;

    // Slice adder and repacking of the payload for the next stage.
    // NOTE: every variable here is assigned on every pass, so no latch is inferred.
    always_comb begin
        sum  = {1'b0, pl_up_i[RES_IN_W + REM_IN_W +: CHUNK]}
             + {1'b0, pl_up_i[RES_IN_W +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_up_i};
        // B's upper slices keep their position; A's shift down by one slice.
        pl_d = OUT_W'((pl_up_i & RES_MASK)
                    | (IN_W'(sum[CHUNK-1:0]) << RES_IN_W)
                    | (pl_up_i & B_HI_MASK)
                    | ((pl_up_i >> CHUNK) & A_HI_MASK));
    end

    // Stage registers advance only when the stage is empty or drains downstream.
    // NOTE: non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            pl_q    <= '0;
        end else if (en_o) begin
            valid_q <= valid_up_i;
            carry_q <= sum[CHUNK];
            pl_q    <= pl_d;
        end
    end

    // An empty stage always accepts, which collapses bubbles under a stall.
    assign en_o    = !valid_q || en_down_i;
    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign pl_o    = pl_q;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: WIDTH-bit adder split into CHUNK-bit slices, one
// slice per stage, with valid/ready backpressure and bubble collapsing.
// Optional feature macro: PCA_SUB_EN adds sub_i (A - B, carry_i ignored).
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_chunk_adder_if.slave bus
);
    localparam int STAGES = stages_f(WIDTH, CHUNK);

    if (!params_ok_f(WIDTH, CHUNK)) begin : g_param_err
        $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin;

    // Operand conditioning: subtraction is A + ~B + 1, folded in before stage 1.
    always_comb begin
`ifdef PCA_SUB_EN
        b_eff = bus.sub_i ? ~bus.data_2 : bus.data_2;
        cin   = bus.sub_i ? 1'b1 : bus.carry_i;
`else
        b_eff = bus.data_2;
        cin   = bus.carry_i;
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic                                      en;
        logic                                      valid;
        logic                                      carry;
        logic [payload_w_f(WIDTH, CHUNK, g+1)-1:0] pl;
        logic                                      en_down;
        logic                                      valid_up;
        logic                                      carry_up;
        logic [payload_w_f(WIDTH, CHUNK, g)-1:0]   pl_up;

        if (g == 0) begin : g_src
            assign valid_up = bus.valid_i && en;
            assign carry_up = cin;
            assign pl_up    = {bus.data_1, b_eff};
        end else begin : g_src
            assign valid_up = g_stage[g-1].valid;
            assign carry_up = g_stage[g-1].carry;
            assign pl_up    = g_stage[g-1].pl;
        end

        if (g == STAGES - 1) begin : g_dst
            assign en_down = bus.ready_i;
        end else begin : g_dst
            assign en_down = g_stage[g+1].en;
        end

        pca_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (g)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_down_i  (en_down),
            .valid_up_i (valid_up),
            .carry_up_i (carry_up),
            .pl_up_i    (pl_up),
            .en_o       (en),
            .valid_o    (valid),
            .carry_o    (carry),
            .pl_o       (pl)
        );
    end

    // ready_o depends only on ready_i and the stage valid bits.
    assign bus.ready_o  = g_stage[0].en;
    assign bus.valid_o  = g_stage[STAGES-1].valid;
    assign bus.data_out = {g_stage[STAGES-1].carry, g_stage[STAGES-1].pl};

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb_pipelined_chunk_adder: scoreboard bench. The driver pushes the expected
// sum of every accepted operand pair; a monitor pops and compares on each
// output transfer. Build with +define+PCA_SUB_EN to cover subtraction.
module tb_pipelined_chunk_adder;

    localparam int W = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_chunk_adder_if #(.WIDTH(W)) bus_if();

    pipelined_chunk_adder #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [W:0] sb[$];
    int         total = 0;
    int         bad   = 0;
    bit         rnd_ready = 1'b0;
    bit         hold_seen = 1'b0;
    logic [W:0] hold_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        int unsigned r = $urandom_range(0, 7);
        if (r == 0) return 16'hFFFF;
        if (r == 1) return 16'h0000;
        return 16'($urandom);
    endfunction

    function automatic logic rnd_sub();
`ifdef PCA_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.valid_i = 1'b0;
    endtask

    // Present one operand pair and hold it until the edge that accepts it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s);
        bus_if.valid_i = 1'b1;
        bus_if.data_1  = a;
        bus_if.data_2  = b;
        bus_if.carry_i = c;
`ifdef PCA_SUB_EN
        bus_if.sub_i   = s;
`endif
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_if.ready_o === 1'b1) begin
                sb.push_back(model(a, b, c, s));
                tick();
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL send_timeout: accepted=0 required=1");
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: compare on every output transfer; check data is held under stall.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_if.valid_o === 1'b1) begin
            if (bus_if.ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got 0x%0h expected none", bus_if.data_out);
                end else begin
                    check("result", 32'(bus_if.data_out), 32'(sb.pop_front()));
                end
                hold_seen = 1'b0;
            end else begin
                if (hold_seen) check("stall_hold", 32'(bus_if.data_out), 32'(hold_val));
                hold_val  = bus_if.data_out;
                hold_seen = 1'b1;
            end
        end else begin
            hold_seen = 1'b0;
        end
    end

    // Random downstream backpressure, active only during the random phase.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            bus_if.ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: finished=0 required=1");
        $fatal(1);
    end

    initial begin
        int acc;

        rst_n          = 1'b0;
        bus_if.valid_i = 1'b0;
        bus_if.data_1  = '0;
        bus_if.data_2  = '0;
        bus_if.carry_i = 1'b0;
        bus_if.ready_i = 1'b1;
`ifdef PCA_SUB_EN
        bus_if.sub_i   = 1'b0;
`endif
        #1;
        check("reset_valid_o", bus_if.valid_o, 0);
        check("reset_data_out", 32'(bus_if.data_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", bus_if.ready_o, 1);

        // Latency and wrap-around: result visible after edge T+3.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle();
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("latency_valid_t%0d", k), bus_if.valid_o, (k == 3) ? 1 : 0);
            tick();
        end
        drain("latency");

        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        idle();
        drain("carry_in");

        // Back-to-back issue: four results on consecutive cycles.
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h8000, 1'b0, 1'b0);
        idle();
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("throughput_valid_%0d", k), bus_if.valid_o, (k < 4) ? 1 : 0);
            tick();
        end
        drain("b2b");

        // Stall: fill the pipe, hold, then release while offering a new operand.
        bus_if.ready_i = 1'b0;
        for (int k = 0; k < 4; k++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0);
        check("stall_ready_low", bus_if.ready_o, 0);
        for (int k = 0; k < 5; k++) begin
            bus_if.valid_i = 1'b1;
            bus_if.data_1  = 16'($urandom);
            bus_if.data_2  = 16'($urandom);
            check($sformatf("stall_ready_hold_%0d", k), bus_if.ready_o, 0);
            tick();
        end
        bus_if.ready_i = 1'b1;
        #1;
        check("release_ready", bus_if.ready_o, 1);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        idle();
        drain("stall");

        // Bubble collapse: pulses every other cycle fill all stages.
        bus_if.ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus_if.ready_o !== 1'b1) break;
            send(rnd_op(), rnd_op(), 1'b0, 1'b0);
            acc++;
            idle();
            tick();
        end
        check("bubble_accepted", acc, 4);
        check("bubble_ready_low", bus_if.ready_o, 0);
        bus_if.ready_i = 1'b1;
        drain("bubble");

        // Reset with three operands in flight.
        bus_if.ready_i = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h6666, 1'b0, 1'b0);
        idle();
        tick();
        check("rst_pre_valid", bus_if.valid_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_valid_o", bus_if.valid_o, 0);
        check("rst_data_out", 32'(bus_if.data_out), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_ready", bus_if.ready_o, 1);
        bus_if.ready_i = 1'b1;
        send(16'h00AA, 16'h0055, 1'b0, 1'b0);
        idle();
        drain("rst");

`ifdef PCA_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b0);
        idle();
        drain("sub");
`endif

        // Random traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), rnd_sub());
            end else begin
                idle();
                tick();
            end
        end
        idle();
        rnd_ready = 1'b0;
        tick();
        bus_if.ready_i = 1'b1;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
